// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM states, instruction field positions and
// the sequential PC increment.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } fetch_state_e;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int IMM_LSB    = 20;
    localparam int IMM_MSB    = 31;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/instr_fields.sv
// Pure combinational slicer of a 32-bit instruction word into its fields;
// shared by every stage that needs decoded register/immediate fields.
module instr_fields
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [11:0] immediate_out
);

    assign opcode        = instr[OPCODE_MSB:OPCODE_LSB];
    assign rd            = instr[RD_MSB:RD_LSB];
    assign funct3        = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign rs1           = instr[RS1_MSB:RS1_LSB];
    assign rs2           = instr[RS2_MSB:RS2_LSB];
    assign immediate_out = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: PC, instruction register and the IDLE/REQ/VALID fetch
// FSM, with stall hold and branch redirect.
module fetch_decode_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [31:0]  branch_target,
    output logic         instr_valid,
    output logic [31:0]  pc_out,
    output logic [31:0]  instr_out,
    output logic [6:0]   opcode,
    output logic [4:0]   rd,
    output logic [2:0]   funct3,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [11:0]  immediate_out,
    output fetch_state_e state_dbg
);

    // Handshakes: imem_req/imem_addr hold steady until a cycle with imem_ack=1
    // completes the fetch; ack with imem_req=0 is ignored. Downstream consumes
    // the held instruction on any cycle with instr_valid=1 and stall=0.
    fetch_state_e state;
    logic [31:0]  pc;

    assign imem_addr = pc;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            pc_out      <= 32'd0;
            instr_out   <= 32'd0;
        end else if (branch_taken) begin
            // Redirect beats stall and drops any ack arriving in this cycle.
            state       <= REQ;
            pc          <= align_word(branch_target);
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        state       <= VALID;
                        instr_out   <= imem_rdata;
                        pc_out      <= pc;
                        pc          <= pc + INSTR_BYTES;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    instr_fields u_fields (
        .instr         (instr_out),
        .opcode        (opcode),
        .rd            (rd),
        .funct3        (funct3),
        .rs1           (rs1),
        .rs2           (rs2),
        .immediate_out (immediate_out)
    );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: directed handshake/stall/branch
// sequences, a decode vector table, and randomized traffic against a model.
module tb_fetch_decode_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, RESET_PC = 0
    logic         rst, imem_req, imem_ack, stall, branch_taken, instr_valid;
    logic [31:0]  imem_addr, imem_rdata, branch_target, pc_out, instr_out;
    logic [6:0]   opcode;
    logic [4:0]   rd, rs1, rs2;
    logic [2:0]   funct3;
    logic [11:0]  immediate_out;
    fetch_state_e state_dbg;

    fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_valid(instr_valid), .pc_out(pc_out), .instr_out(instr_out),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .immediate_out(immediate_out), .state_dbg(state_dbg)
    );

    // Second instance for PC wrap-around from the top of the address space
    logic         w_rst, w_req, w_ack, w_valid;
    logic [31:0]  w_addr, w_rdata, w_pc_out, w_instr_out;
    logic [6:0]   w_opcode;
    logic [4:0]   w_rd, w_rs1, w_rs2;
    logic [2:0]   w_funct3;
    logic [11:0]  w_imm;
    fetch_state_e w_state;

    fetch_decode_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'd0),
        .instr_valid(w_valid), .pc_out(w_pc_out), .instr_out(w_instr_out),
        .opcode(w_opcode), .rd(w_rd), .funct3(w_funct3), .rs1(w_rs1), .rs2(w_rs2),
        .immediate_out(w_imm), .state_dbg(w_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic [31:0] sext;
    } vec_t;

    vec_t vecs[5];

    // Behavioural model state for the random phase
    logic        m_idle, m_req, m_valid;
    logic [31:0] m_pc, m_pc_out, m_instr;
    logic [31:0] exp_q[$];

    task automatic model_reset();
        m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0;
        m_pc = 32'd0; m_pc_out = 32'd0; m_instr = 32'd0;
        exp_q.delete();
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (branch_taken) begin
            m_pc = branch_target & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_req = 1'b1; m_idle = 1'b0;
            exp_q.delete();
        end else if (m_idle) begin
            m_idle = 1'b0; m_req = 1'b1;
        end else if (m_req && imem_ack) begin
            m_instr = imem_rdata; m_pc_out = m_pc; m_pc = m_pc + 32'd4;
            m_valid = 1'b1; m_req = 1'b0;
            exp_q.push_back(imem_rdata);
        end else if (m_valid && !stall) begin
            m_valid = 1'b0; m_req = 1'b1;
        end
    endtask

    logic [31:0] exp_pc, held, popped;

    initial begin
        vecs[0] = '{32'hFFF0_0093, 7'h13, 5'd1,  3'd0, 5'd0, 5'h1F, 12'hFFF, 32'hFFFF_FFFF};
        vecs[1] = '{32'h00A2_8293, 7'h13, 5'd5,  3'd0, 5'd5, 5'h0A, 12'h00A, 32'h0000_000A};
        vecs[2] = '{32'h0020_A023, 7'h23, 5'd0,  3'd2, 5'd1, 5'h02, 12'h002, 32'h0000_0002};
        vecs[3] = '{32'h8000_0000, 7'h00, 5'd0,  3'd0, 5'd0, 5'h00, 12'h800, 32'hFFFF_F800};
        vecs[4] = '{32'h0000_0F80, 7'h00, 5'h1F, 3'd0, 5'd0, 5'h00, 12'h000, 32'h0000_0000};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0;
        w_rst = 1'b1; w_ack = 1'b0; w_rdata = 32'd0;

        // Reset: held two cycles, all outputs zero
        tick(); tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_fields", {opcode, rd, funct3, rs1, rs2, 7'd0}, 32'd0);
        check("rst_imm", 32'(immediate_out), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        check("idle_req", 32'(imem_req), 32'd0);
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'd0);

        // Decode of the first fetched word
        imem_ack = 1'b1; imem_rdata = 32'hFFF0_0093;
        tick();
        imem_ack = 1'b0;
        check("dec_valid", 32'(instr_valid), 32'd1);
        check("dec_pc_out", pc_out, 32'd0);
        check("dec_opcode", 32'(opcode), 32'h13);
        check("dec_rd", 32'(rd), 32'd1);
        check("dec_rs1", 32'(rs1), 32'd0);
        check("dec_funct3", 32'(funct3), 32'd0);
        check("dec_imm", 32'(immediate_out), 32'hFFF);
        check("dec_sext", {{20{immediate_out[11]}}, immediate_out}, 32'hFFFF_FFFF);
        check("dec_req_low", 32'(imem_req), 32'd0);

        // Wait states: address stays at 4 while ack is withheld
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, 32'd4);
            tick();
        end
        check("wait_addr_ack", imem_addr, 32'd4);
        imem_ack = 1'b1; imem_rdata = 32'h00A2_8293;
        stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr_out, 32'h00A2_8293);
            check("stall_pc_out", pc_out, 32'd4);
            check("stall_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("post_stall_req", 32'(imem_req), 32'd1);
        check("post_stall_addr", imem_addr, 32'd8);

        // Decode table
        exp_pc = 32'd8;
        foreach (vecs[i]) begin
            check("tbl_req", 32'(imem_req), 32'd1);
            check("tbl_addr", imem_addr, exp_pc);
            imem_ack = 1'b1; imem_rdata = vecs[i].instr;
            tick();
            imem_ack = 1'b0;
            check("tbl_valid", 32'(instr_valid), 32'd1);
            check("tbl_pc_out", pc_out, exp_pc);
            check("tbl_opcode", 32'(opcode), 32'(vecs[i].op));
            check("tbl_rd", 32'(rd), 32'(vecs[i].rd));
            check("tbl_funct3", 32'(funct3), 32'(vecs[i].f3));
            check("tbl_rs1", 32'(rs1), 32'(vecs[i].rs1));
            check("tbl_rs2", 32'(rs2), 32'(vecs[i].rs2));
            check("tbl_imm", 32'(immediate_out), 32'(vecs[i].imm));
            check("tbl_sext", {{20{immediate_out[11]}}, immediate_out}, vecs[i].sext);
            exp_pc = exp_pc + 32'd4;
            tick();
        end

        // Branch with simultaneous ack in REQ: word discarded
        held = instr_out;
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        branch_taken = 1'b0; imem_ack = 1'b0;
        check("br_valid", 32'(instr_valid), 32'd0);
        check("br_instr_kept", instr_out, held);
        check("br_req", 32'(imem_req), 32'd1);
        check("br_addr", imem_addr, 32'h0000_0100);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        check("br_fetch_pc", pc_out, 32'h0000_0100);
        check("br_fetch_valid", 32'(instr_valid), 32'd1);

        // Ack while not requesting is ignored
        stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 1'b0;
        check("stray_ack_instr", instr_out, 32'h1234_5678);
        check("stray_ack_valid", 32'(instr_valid), 32'd1);

        // Branch overrides stall in VALID
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        check("brs_valid", 32'(instr_valid), 32'd0);
        check("brs_req", 32'(imem_req), 32'd1);
        check("brs_addr", imem_addr, 32'h0000_0200);

        // Mid-fetch reset, then a late ack
        rst = 1'b1;
        tick();
        check("mrst_req", 32'(imem_req), 32'd0);
        check("mrst_addr", imem_addr, 32'd0);
        check("mrst_instr", instr_out, 32'd0);
        check("mrst_pc_out", pc_out, 32'd0);
        rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        tick();
        imem_ack = 1'b0;
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("late_ack_instr", instr_out, 32'd0);

        // Wrap-around instance
        w_rst = 1'b0;
        tick();
        check("wrap_req", 32'(w_req), 32'd1);
        check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        w_ack = 1'b1; w_rdata = 32'h0000_0013;
        tick();
        w_ack = 1'b0;
        check("wrap_pc_out", w_pc_out, 32'hFFFF_FFFC);
        check("wrap_valid", 32'(w_valid), 32'd1);
        tick();
        check("wrap_req2", 32'(w_req), 32'd1);
        check("wrap_addr1", w_addr, 32'd0);
        w_rst = 1'b1;
        tick();
        check("wrap_rst_req", 32'(w_req), 32'd0);
        check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        w_rst = 1'b0; w_ack = 1'b1;
        tick();
        w_ack = 1'b0;
        check("wrap_late_ack", 32'(w_valid), 32'd0);

        // Randomized traffic against the model
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            imem_ack      = 1'($urandom_range(0, 1));
            imem_rdata    = $urandom;
            stall         = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 11) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
            rst           = ($urandom_range(0, 79) == 0);
            // Scoreboard: the held instruction is consumed on valid && !stall
            if (!rst && !branch_taken && instr_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    popped = exp_q.pop_front();
                    check("sb_consumed", instr_out, popped);
                end
            end
            model_step();
            tick();
            check("rnd_req", 32'(imem_req), 32'(m_req));
            if (m_req) check("rnd_addr", imem_addr, m_pc);
            check("rnd_valid", 32'(instr_valid), 32'(m_valid));
            check("rnd_pc_out", pc_out, m_pc_out);
            check("rnd_instr", instr_out, m_instr);
            check("rnd_opcode", 32'(opcode), m_instr & 32'h7F);
            check("rnd_rd", 32'(rd), (m_instr >> 7) & 32'h1F);
            check("rnd_funct3", 32'(funct3), (m_instr >> 12) & 32'h7);
            check("rnd_rs1", 32'(rs1), (m_instr >> 15) & 32'h1F);
            check("rnd_rs2", 32'(rs2), (m_instr >> 20) & 32'h1F);
            check("rnd_imm", 32'(immediate_out), m_instr >> 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
